// File: rtl/sdram_pro_arbit_pkg.sv
// Shared definitions for the SDRAM command arbiter: command encodings
// ({cs_n, ras_n, cas_n, we_n}), arbiter state encoding and grant owner type.
package sdram_pro_arbit_pkg;

    localparam logic [3:0] NO_OPERATION = 4'b0111;
    localparam logic [3:0] PRECHARGE    = 4'b0010;
    localparam logic [3:0] AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] ACTIVE       = 4'b0011;
    localparam logic [3:0] WRITE        = 4'b0100;
    localparam logic [3:0] READ         = 4'b0101;
    localparam logic [3:0] LOAD_MODE    = 4'b0000;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_ATREF = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    // Which of the two data engines was granted most recently.
    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

endpackage

// File: rtl/sdram_pro_arbit_if.sv
// Engine-side and SDRAM-side bus of the arbiter.
//
// Handshake: an engine raises x_req (level) and keeps it up until the
// arbiter answers with a one-cycle x_en pulse; from then on the engine owns
// the command bus until it pulses x_end for one cycle. Requests are only
// looked at while the arbiter is idle, and an end pulse only counts when it
// comes from the engine that currently owns the bus.
interface sdram_pro_arbit_if #(
    parameter int CMD_W  = 4,
    parameter int BA_W   = 2,
    parameter int ADDR_W = 12
) ();
    import sdram_pro_arbit_pkg::*;

    logic              init_end;
    logic [CMD_W-1:0]  init_cmd;
    logic [BA_W-1:0]   init_bank;
    logic [ADDR_W-1:0] init_addr;

    logic              atref_req;
    logic              atref_end;
    logic [CMD_W-1:0]  atref_cmd;
    logic [BA_W-1:0]   atref_bank;
    logic [ADDR_W-1:0] atref_addr;

    logic              wr_req;
    logic              wr_end;
    logic [CMD_W-1:0]  wr_cmd;
    logic [BA_W-1:0]   wr_bank;
    logic [ADDR_W-1:0] wr_addr;

    logic              rd_req;
    logic              rd_end;
    logic [CMD_W-1:0]  rd_cmd;
    logic [BA_W-1:0]   rd_bank;
    logic [ADDR_W-1:0] rd_addr;

    logic              atref_en;
    logic              wr_en;
    logic              rd_en;

    logic              sdram_cke;
    logic              sdram_cs_n;
    logic              sdram_ras_n;
    logic              sdram_cas_n;
    logic              sdram_we_n;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;

    // Current arbiter state, exported for observation.
    state_t            fsm_state;

    modport slave (
        input  init_end, init_cmd, init_bank, init_addr,
        input  atref_req, atref_end, atref_cmd, atref_bank, atref_addr,
        input  wr_req, wr_end, wr_cmd, wr_bank, wr_addr,
        input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
        output atref_en, wr_en, rd_en,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_ba, sdram_addr,
        output fsm_state
    );

    modport master (
        output init_end, init_cmd, init_bank, init_addr,
        output atref_req, atref_end, atref_cmd, atref_bank, atref_addr,
        output wr_req, wr_end, wr_cmd, wr_bank, wr_addr,
        output rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
        input  atref_en, wr_en, rd_en,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_ba, sdram_addr,
        input  fsm_state
    );

endinterface

// File: rtl/sdram_pro_rr2.sv
// Two-way round-robin selector between the write and read engines.
// The result is only meaningful while at least one request is present.
module sdram_pro_rr2
    import sdram_pro_arbit_pkg::*;
(
    input  logic   wr_req,
    input  logic   rd_req,
    input  grant_t last_grant,
    output grant_t grant
);

    // When both ask, hand the bus to whichever did not have it last time.
    always_comb begin
        grant = GRANT_WR;
        if (wr_req && rd_req) begin
            grant = (last_grant == GRANT_RD) ? GRANT_WR : GRANT_RD;
        end else if (rd_req) begin
            grant = GRANT_RD;
        end
    end

endmodule

// File: rtl/sdram_pro_arbit.sv
// SDRAM command arbiter: waits for init, then shares the command bus between
// refresh (highest priority) and the write/read engines (round-robin).
// All pins are registered, so every engine sees the same one-cycle latency.
module sdram_pro_arbit
    import sdram_pro_arbit_pkg::*;
#(
    parameter int CMD_W  = 4,
    parameter int BA_W   = 2,
    parameter int ADDR_W = 12
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    sdram_pro_arbit_if.slave   bus
);

    state_t            state, state_next;
    grant_t            last_grant, last_grant_next;
    grant_t            rr_grant;
    logic              atref_en_q, wr_en_q, rd_en_q;
    logic              atref_en_next, wr_en_next, rd_en_next;
    logic [CMD_W-1:0]  cmd_q, cmd_next;
    logic [BA_W-1:0]   ba_q, ba_next;
    logic [ADDR_W-1:0] addr_q, addr_next;

    sdram_pro_rr2 u_rr2 (
        .wr_req     (bus.wr_req),
        .rd_req     (bus.rd_req),
        .last_grant (last_grant),
        .grant      (rr_grant)
    );

    // State, grant history, grant pulses and pin registers.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= ST_INIT;
            last_grant <= GRANT_RD;
            atref_en_q <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            cmd_q      <= NO_OPERATION;
            ba_q       <= '1;
            addr_q     <= '1;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            atref_en_q <= atref_en_next;
            wr_en_q    <= wr_en_next;
            rd_en_q    <= rd_en_next;
            cmd_q      <= cmd_next;
            ba_q       <= ba_next;
            addr_q     <= addr_next;
        end
    end

    // Next state, grant pulses and pin mux; the mux follows the current owner.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        atref_en_next   = 1'b0;
        wr_en_next      = 1'b0;
        rd_en_next      = 1'b0;
        cmd_next        = NO_OPERATION;
        ba_next         = '1;
        addr_next       = '1;
        case (state)
            ST_INIT: begin
                cmd_next  = bus.init_cmd;
                ba_next   = bus.init_bank;
                addr_next = bus.init_addr;
                if (bus.init_end) begin
                    state_next = ST_ARBIT;
                end
            end
            ST_ARBIT: begin
                if (bus.atref_req) begin
                    state_next    = ST_ATREF;
                    atref_en_next = 1'b1;
                end else if (bus.wr_req || bus.rd_req) begin
                    if (rr_grant == GRANT_WR) begin
                        state_next      = ST_WRITE;
                        wr_en_next      = 1'b1;
                        last_grant_next = GRANT_WR;
                    end else begin
                        state_next      = ST_READ;
                        rd_en_next      = 1'b1;
                        last_grant_next = GRANT_RD;
                    end
                end
            end
            ST_ATREF: begin
                cmd_next  = bus.atref_cmd;
                ba_next   = bus.atref_bank;
                addr_next = bus.atref_addr;
                if (bus.atref_end) begin
                    state_next = ST_ARBIT;
                end
            end
            ST_WRITE: begin
                cmd_next  = bus.wr_cmd;
                ba_next   = bus.wr_bank;
                addr_next = bus.wr_addr;
                if (bus.wr_end) begin
                    state_next = ST_ARBIT;
                end
            end
            ST_READ: begin
                cmd_next  = bus.rd_cmd;
                ba_next   = bus.rd_bank;
                addr_next = bus.rd_addr;
                if (bus.rd_end) begin
                    state_next = ST_ARBIT;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    assign bus.atref_en    = atref_en_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.sdram_cke   = 1'b1;
    assign bus.sdram_cs_n  = cmd_q[3];
    assign bus.sdram_ras_n = cmd_q[2];
    assign bus.sdram_cas_n = cmd_q[1];
    assign bus.sdram_we_n  = cmd_q[0];
    assign bus.sdram_ba    = ba_q;
    assign bus.sdram_addr  = addr_q;
    assign bus.fsm_state   = state;

endmodule

// File: tb/tb_sdram_pro_arbit.sv
// Self-checking bench for sdram_pro_arbit: directed sequences with a grant
// scoreboard fed when requests are driven and drained by the grant monitor.
module tb_sdram_pro_arbit;
    import sdram_pro_arbit_pkg::*;

    localparam logic [17:0] NOP_PINS = {NO_OPERATION, 2'b11, 12'hfff};
    localparam logic [2:0]  G_A = 3'b100;
    localparam logic [2:0]  G_W = 3'b010;
    localparam logic [2:0]  G_R = 3'b001;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_grant;

    sdram_pro_arbit_if #(.CMD_W(4), .BA_W(2), .ADDR_W(12)) bus ();

    sdram_pro_arbit #(.CMD_W(4), .BA_W(2), .ADDR_W(12)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    // clock / watchdog
    always #5 sys_clk = ~sys_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", tag, got, exp);
    endtask

    function automatic logic [17:0] pins();
        return {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
                bus.sdram_ba, bus.sdram_addr};
    endfunction

    function automatic logic [2:0] ens();
        return {bus.atref_en, bus.wr_en, bus.rd_en};
    endfunction

    function automatic logic [17:0] bus_of(input logic [2:0] g);
        case (g)
            G_A:     return {bus.atref_cmd, bus.atref_bank, bus.atref_addr};
            G_W:     return {bus.wr_cmd, bus.wr_bank, bus.wr_addr};
            default: return {bus.rd_cmd, bus.rd_bank, bus.rd_addr};
        endcase
    endfunction

    function automatic state_t st_of(input logic [2:0] g);
        case (g)
            G_A:     return ST_ATREF;
            G_W:     return ST_WRITE;
            default: return ST_READ;
        endcase
    endfunction

    // grant monitor: every pulse must match the next expected grant
    always @(negedge sys_clk) begin
        if (ens() != 3'b000) begin
            exp_grant = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b000;
            check("grant", ens(), exp_grant);
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Expect a grant on the next edge; pulse must be one cycle, pins follow
    // the engine bus one cycle after entry.
    task automatic expect_grant(input logic [2:0] g);
        case (g)
            G_A:     bus.atref_addr = 12'($urandom_range(0, 4095));
            G_W:     bus.wr_addr    = 12'($urandom_range(0, 4095));
            default: bus.rd_addr    = 12'($urandom_range(0, 4095));
        endcase
        exp_q.push_back(g);
        tick();
        check("grant_state", bus.fsm_state, st_of(g));
        if (g == G_A) bus.atref_req = 1'b0;
        tick();
        check("grant_pulse_width", ens(), 3'b000);
        check("grant_pins", pins(), bus_of(g));
    endtask

    task automatic end_op(input logic [2:0] g);
        case (g)
            G_A:     bus.atref_end = 1'b1;
            G_W:     bus.wr_end    = 1'b1;
            default: bus.rd_end    = 1'b1;
        endcase
        tick();
        bus.atref_end = 1'b0;
        bus.wr_end    = 1'b0;
        bus.rd_end    = 1'b0;
        check("end_to_arbit", bus.fsm_state, ST_ARBIT);
    endtask

    initial begin
        bus.init_end = 1'b0;  bus.init_cmd = PRECHARGE; bus.init_bank = 2'b00; bus.init_addr = 12'h400;
        bus.atref_req = 1'b0; bus.atref_end = 1'b0;
        bus.atref_cmd = AUTO_REFRESH; bus.atref_bank = 2'b01; bus.atref_addr = 12'h111;
        bus.wr_req = 1'b0; bus.wr_end = 1'b0; bus.wr_cmd = WRITE; bus.wr_bank = 2'b10; bus.wr_addr = 12'h222;
        bus.rd_req = 1'b0; bus.rd_end = 1'b0; bus.rd_cmd = READ;  bus.rd_bank = 2'b00; bus.rd_addr = 12'h333;

        // reset and init
        sys_rst_n = 1'b0;
        repeat (3) tick();
        check("rst_state", bus.fsm_state, ST_INIT);
        check("rst_pins", pins(), NOP_PINS);
        check("rst_en", ens(), 3'b000);
        check("rst_cke", bus.sdram_cke, 1'b1);
        sys_rst_n = 1'b1;
        tick();
        check("init_pins", pins(), {PRECHARGE, 2'b00, 12'h400});
        check("init_hold", bus.fsm_state, ST_INIT);
        bus.init_cmd = NO_OPERATION;
        bus.init_end = 1'b1;
        tick();
        check("init_to_arbit", bus.fsm_state, ST_ARBIT);
        tick();
        check("arbit_pins", pins(), NOP_PINS);
        bus.init_end = 1'b0;
        tick();
        check("init_end_fall", bus.fsm_state, ST_ARBIT);

        // refresh alone
        bus.atref_req = 1'b1;
        expect_grant(G_A);
        repeat (2) tick();
        end_op(G_A);
        tick();
        check("atref_nop_pins", pins(), NOP_PINS);
        check("atref_idle", bus.fsm_state, ST_ARBIT);

        // write/read alternation W,R,W,R
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        expect_grant(G_W);
        bus.rd_end = 1'b1;
        tick();
        bus.rd_end = 1'b0;
        check("foreign_end", bus.fsm_state, ST_WRITE);
        for (int i = 1; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            end_op((i % 2) ? G_W : G_R);
            expect_grant((i % 2) ? G_R : G_W);
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        end_op(G_R);
        tick();
        check("rr_idle", bus.fsm_state, ST_ARBIT);
        check("rr_idle_pins", pins(), NOP_PINS);

        // refresh beats a simultaneous write request
        bus.atref_req = 1'b1;
        bus.wr_req = 1'b1;
        expect_grant(G_A);
        repeat (2) tick();
        end_op(G_A);
        expect_grant(G_W);

        // write request raised during a read waits for rd_end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b1;
        end_op(G_W);
        expect_grant(G_R);
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_read", bus.fsm_state, ST_READ);
        end
        end_op(G_R);
        expect_grant(G_W);

        // reset during a write
        bus.wr_req = 1'b0;
        bus.atref_req = 1'b1;
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        check("midrst_state", bus.fsm_state, ST_INIT);
        check("midrst_en", ens(), 3'b000);
        check("midrst_pins", pins(), NOP_PINS);
        bus.wr_end = 1'b1;
        bus.rd_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        bus.rd_end = 1'b0;
        check("ends_in_init", bus.fsm_state, ST_INIT);
        check("reinit_pins", pins(), {NO_OPERATION, 2'b00, 12'h400});
        bus.init_end = 1'b1;
        tick();
        check("reinit_arbit", bus.fsm_state, ST_ARBIT);
        expect_grant(G_A);
        end_op(G_A);
        repeat (2) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
